// File: rtl/counter_123_accum.sv
// Frame accumulator for the (1,2,3) counter output stream.
// Sums beats until in_last, then parks the total in a one-entry output buffer.
module counter_123_accum #(
  parameter int unsigned ACC_W = 16,
  parameter bit          SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_o,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_beats,
  output logic             out_ovf,
  output logic             out_err
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_ACCUM = 1'b1;

  logic             state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       beats_q, beats_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [7:0]       out_beats_q, out_beats_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_err_q, out_err_d;

  logic             accept;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   sum_wide;
  logic             carry;
  logic [ACC_W-1:0] acc_next;
  logic [7:0]       beats_next;
  logic             ovf_next;
  logic             err_next;

  always_comb begin
    in_ready   = !rst && !(out_valid_q && !out_ready);
    accept     = in_valid && in_ready;
    acc_base   = (state_q == ST_IDLE) ? '0 : acc_q;
    sum_wide   = {1'b0, acc_base} + {{(ACC_W - 3){1'b0}}, in_o};
    carry      = sum_wide[ACC_W];
    // Out-of-range beats are still summed as-is; they only raise err.
    if (carry && SAT) acc_next = {ACC_W{1'b1}};
    else              acc_next = sum_wide[ACC_W-1:0];
    beats_next = (beats_q == 8'hff) ? 8'hff : beats_q + 8'd1;
    ovf_next   = ovf_q | carry;
    err_next   = err_q | (in_o > 4'd11);
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beats_d     = beats_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_beats_d = out_beats_q;
    out_ovf_d   = out_ovf_q;
    out_err_d   = out_err_q;

    if (out_ready) out_valid_d = 1'b0;

    if (accept) begin
      if (in_last) begin
        out_valid_d = 1'b1;
        out_sum_d   = acc_next;
        out_beats_d = beats_next;
        out_ovf_d   = ovf_next;
        out_err_d   = err_next;
        state_d     = ST_IDLE;
        acc_d       = '0;
        beats_d     = 8'd0;
        ovf_d       = 1'b0;
        err_d       = 1'b0;
      end else begin
        state_d = ST_ACCUM;
        acc_d   = acc_next;
        beats_d = beats_next;
        ovf_d   = ovf_next;
        err_d   = err_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      beats_q     <= 8'd0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_beats_q <= 8'd0;
      out_ovf_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beats_q     <= beats_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_beats_q <= out_beats_d;
      out_ovf_q   <= out_ovf_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_beats = out_beats_q;
  assign out_ovf   = out_ovf_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_counter_123_accum.sv
// Bench for counter_123_accum: three instances (16-bit saturating, 6-bit saturating,
// 6-bit wrapping) share one input stream; a reference model fills per-instance queues.
module tb_counter_123_accum;

  typedef struct {
    longint sum;
    int     beats;
    bit     ovf;
    bit     err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_o;
  logic       in_last;
  logic       out_ready;

  logic        rdy_a, rdy_b, rdy_c;
  logic        v_a, v_b, v_c;
  logic [15:0] sum_a;
  logic [5:0]  sum_b, sum_c;
  logic [7:0]  beats_a, beats_b, beats_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic        err_a, err_b, err_c;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  int unsigned w_cfg[3]   = '{16, 6, 6};
  bit          sat_cfg[3] = '{1'b1, 1'b1, 1'b0};
  longint      m_acc[3];
  bit          m_ovf[3];
  int          m_beats;
  bit          m_err;

  always #5 clk = ~clk;

  counter_123_accum #(.ACC_W(16), .SAT(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .in_o(in_o),
    .in_last(in_last), .out_valid(v_a), .out_ready(out_ready), .out_sum(sum_a),
    .out_beats(beats_a), .out_ovf(ovf_a), .out_err(err_a)
  );

  counter_123_accum #(.ACC_W(6), .SAT(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .in_o(in_o),
    .in_last(in_last), .out_valid(v_b), .out_ready(out_ready), .out_sum(sum_b),
    .out_beats(beats_b), .out_ovf(ovf_b), .out_err(err_b)
  );

  counter_123_accum #(.ACC_W(6), .SAT(1'b0)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c), .in_o(in_o),
    .in_last(in_last), .out_valid(v_c), .out_ready(out_ready), .out_sum(sum_c),
    .out_beats(beats_c), .out_ovf(ovf_c), .out_err(err_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cmp_res(input string tag, input exp_t e, input logic [31:0] sum,
                         input logic [7:0] beats, input logic ovf, input logic err);
    check({tag, ".sum"}, sum, 32'(e.sum));
    check({tag, ".beats"}, {24'd0, beats}, 32'(e.beats));
    check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, e.ovf});
    check({tag, ".err"}, {31'd0, err}, {31'd0, e.err});
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0;
      m_ovf[i] = 1'b0;
    end
    m_beats = 0;
    m_err   = 1'b0;
  endfunction

  function automatic void model_accept(input logic [3:0] o, input logic last);
    longint max, s;
    exp_t   e;
    for (int i = 0; i < 3; i++) begin
      max = (longint'(1) << w_cfg[i]) - 1;
      s   = m_acc[i] + longint'(o);
      if (s > max) begin
        m_ovf[i] = 1'b1;
        m_acc[i] = sat_cfg[i] ? max : (s & max);
      end else begin
        m_acc[i] = s;
      end
    end
    if (m_beats < 255) m_beats++;
    if (o > 4'd11) m_err = 1'b1;
    if (last) begin
      e.beats = m_beats;
      e.err   = m_err;
      e.sum = m_acc[0]; e.ovf = m_ovf[0]; q_a.push_back(e);
      e.sum = m_acc[1]; e.ovf = m_ovf[1]; q_b.push_back(e);
      e.sum = m_acc[2]; e.ovf = m_ovf[2]; q_c.push_back(e);
      model_clear();
    end
  endfunction

  // A buffered result is compared exactly once, in the cycle it is drained.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && v_a && out_ready) begin
      if (q_a.size() == 0) check("a.spurious", 32'd1, 32'd0);
      else begin e = q_a.pop_front(); cmp_res("a", e, 32'(sum_a), beats_a, ovf_a, err_a); end
    end
    if (!rst && v_b && out_ready) begin
      if (q_b.size() == 0) check("b.spurious", 32'd1, 32'd0);
      else begin e = q_b.pop_front(); cmp_res("b", e, 32'(sum_b), beats_b, ovf_b, err_b); end
    end
    if (!rst && v_c && out_ready) begin
      if (q_c.size() == 0) check("c.spurious", 32'd1, 32'd0);
      else begin e = q_c.pop_front(); cmp_res("c", e, 32'(sum_c), beats_c, ovf_c, err_c); end
    end
  end

  task automatic send(input logic [3:0] o, input logic last, output int waits);
    in_valid = 1'b1;
    in_o     = o;
    in_last  = last;
    waits    = 0;
    @(negedge clk);
    while (!rdy_a && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    check("accept", {31'd0, rdy_a}, 32'd1);
    if (rdy_a) model_accept(o, last);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    int w;
    model_clear();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_o      = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.in_ready", {31'd0, rdy_a}, 32'd0);
    check("rst.out_valid", {31'd0, v_a}, 32'd0);
    check("rst.out_sum", 32'(sum_a), 32'd0);
    check("rst.out_beats", {24'd0, beats_a}, 32'd0);
    check("rst.flags", {30'd0, ovf_a, err_a}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst.in_ready", {31'd0, rdy_a}, 32'd1);
    @(posedge clk);
    #1;

    // Basic frame; result must be visible one cycle after the last beat.
    send(4'd3, 1'b0, w);
    send(4'd11, 1'b0, w);
    send(4'd0, 1'b0, w);
    send(4'd7, 1'b1, w);
    @(negedge clk);
    check("lat.out_valid", {31'd0, v_a}, 32'd1);
    check("lat.out_sum", 32'(sum_a), 32'd21);
    @(posedge clk);
    #1;

    // Back-to-back single-beat frames at full rate.
    send(4'd5, 1'b1, w);  check("tput0", 32'(w), 32'd0);
    send(4'd9, 1'b1, w);  check("tput1", 32'(w), 32'd0);
    send(4'd11, 1'b1, w); check("tput2", 32'(w), 32'd0);

    // Six beats of 11: 66 overflows the 6-bit instances.
    for (int i = 0; i < 6; i++) send(4'd11, i == 5, w);

    // Out-of-range beats, then a clean frame.
    send(4'd12, 1'b0, w);
    send(4'd15, 1'b1, w);
    send(4'd1, 1'b1, w);
    @(posedge clk);
    #1;

    // Backpressure: buffer full with 8, next beat pending for 3 cycles.
    out_ready = 1'b0;
    send(4'd4, 1'b0, w);
    send(4'd4, 1'b1, w);
    in_valid = 1'b1;
    in_o     = 4'd1;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp.in_ready", {31'd0, rdy_a}, 32'd0);
      check("bp.out_sum", 32'(sum_a), 32'd8);
      check("bp.out_valid", {31'd0, v_a}, 32'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp.resume", {31'd0, rdy_a}, 32'd1);
    if (rdy_a) model_accept(4'd1, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-frame: the partial 6,6 frame must never appear.
    send(4'd6, 1'b0, w);
    send(4'd6, 1'b0, w);
    rst = 1'b1;
    @(negedge clk);
    check("midrst.in_ready", {31'd0, rdy_a}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    send(4'd2, 1'b1, w);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("end.q_a", 32'(q_a.size()), 32'd0);
    check("end.q_b", 32'(q_b.size()), 32'd0);
    check("end.q_c", 32'(q_c.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_123_accum.md
# counter_123_accum

Streaming accumulator that sits directly downstream of the (1,2,3) counter stage in the Versal compressor datapath. It consumes the counter's 4-bit result O (range 0..11), one beat per cycle under a valid/ready handshake, and sums beats into a frame total delimited by `in_last`. Each completed frame total is held in a one-entry registered output buffer with its beat count and overflow/range flags. The buffer is drained by the next arithmetic stage.

## Interface
- `ACC_W`, 16: accumulator and `out_sum` width. Legal range 6..32.
- `SAT`, 1: 1 = saturate at 2^ACC_W-1; 0 = wrap modulo 2^ACC_W.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_o`  in  4  counter result for this beat (legal 0..11).
- `in_last`  in  1  beat is the final beat of its frame.
- `out_valid`  out  1  output buffer holds a completed frame.
- `out_ready`  in  1  downstream takes the buffer this cycle.
- `out_sum`  out  ACC_W  frame total.
- `out_beats`  out  8  beats in frame; saturates at 255.
- `out_ovf`  out  1  accumulator overflowed during the frame (saturated or wrapped).
- `out_err`  out  1  at least one beat had `in_o` > 11.

## Operation
- Accept: a beat is accepted when `in_valid && in_ready`.
- Ready rule: `in_ready = !rst && !(out_valid && !out_ready)`. Non-last beats are also stalled while the buffer is full and not draining.
- Frame state: `acc` (ACC_W), `beats` (8), `ovf`, `err`. There are two states:
  - IDLE: `acc` = 0, no beat yet in the frame.
  - ACCUM: at least one beat has been accepted.
- Transitions:
  - IDLE→ACCUM on an accepted non-last beat.
  - ACCUM→IDLE on an accepted last beat.
  - An accepted last beat in IDLE (single-beat frame) stays in IDLE.
- Per accepted beat, compute `next = acc + in_o` at ACC_W+1 bits.
  - If the carry is set: with SAT=1, `next` = all-ones; with SAT=0, `next` = the low ACC_W bits. In both cases `ovf` is set for the frame.
  - `beats` increments and saturates at 255.
  - `err` is set if `in_o` > 11. The value is still added unmodified.
- Last beat: the frame's final `next`, `beats`, `ovf` and `err` values (including this beat) load the output buffer, and `out_valid` is set. Frame state clears to IDLE values in the same cycle. No bubble between frames.
- Buffer: `out_valid` clears when `out_ready` is high and no new last beat loads in that cycle. A simultaneous drain and load keeps `out_valid` = 1 with the new contents.
- Output fields are stable while `out_valid && !out_ready`.

## Timing
- Reset values (cycle after `rst` is sampled high):
  - `out_valid` = 0, `out_sum` = 0, `out_beats` = 0, `out_ovf` = 0, `out_err` = 0.
  - Internal `acc`/`beats`/`ovf`/`err` = 0; state IDLE.
  - `in_ready` = 0 while `rst` is high, and 1 from the first cycle after.
- Reset mid-frame discards the partial frame and any buffered, undrained result. The first post-reset beat starts a fresh frame.
- Latency: last beat accepted in cycle N → `out_valid` = 1 with the frame result in cycle N+1.
- Throughput: 1 beat/cycle sustained when `out_ready` is held high, including back-to-back single-beat frames.
- Backpressure: if `out_valid` = 1 and `out_ready` = 0 in cycle N, no beat is accepted in cycle N. Acceptance resumes combinationally in the cycle `out_ready` rises.
- `in_ready` depends combinationally on `out_ready`; there are no other input-to-output combinational paths.

## Test plan
- Reset, then a frame of beats 3,11,0,7 (last on 7), with `out_ready`=1 → one cycle after the last beat: `out_valid`=1, `out_sum`=21, `out_beats`=4, `out_ovf`=0, `out_err`=0.
- Back-to-back single-beat frames 5,9,11, all `in_last`=1, `out_ready`=1 → `in_ready` stays 1; `out_sum` sequence 5,9,11 on consecutive cycles, each `out_beats`=1.
- ACC_W=6, SAT=1: six beats of 11 → `out_sum`=63, `out_ovf`=1, `out_beats`=6. With SAT=0, same stimulus → `out_sum`=2, `out_ovf`=1.
- Beat values 12 then 15 (last) → `out_sum`=27, `out_err`=1. The next frame of value 1 → `out_err`=0.
- Frame 4,4 (last) completes with `out_ready`=0 for 3 cycles, with a new frame pending → `in_ready`=0 for those 3 cycles; `out_sum` holds 8. When `out_ready` rises, the pending beat is accepted in that same cycle.
- Two beats of a frame (6,6) accepted, then `rst` pulsed for 1 cycle, then a frame with a single beat 2 → `out_sum`=2, `out_beats`=1. No result is emitted for the aborted frame.
